input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter NUM_CH, default 5: number of independent button channels, legal range 1..32.
REQ-002 Parameter SAMPLE_DIV, default 11: clocks per sample tick, legal range >=1.
REQ-003 Parameter STABLE_SAMPLES, default 3: consecutive differing samples required to accept a level change, legal range >=1.
REQ-004 Parameter REPEAT_DELAY, default 25: sample ticks from press to first auto-repeat, legal range >=1.
REQ-005 Parameter REPEAT_RATE, default 6: sample ticks between subsequent auto-repeats, legal range >=1.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, asynchronous assertion, active-high.
REQ-008 raw_in  input  NUM_CH  asynchronous button levels, 1 = pressed.
REQ-009 repeat_en  input  NUM_CH  per-channel auto-repeat enable, sampled on ticks.
REQ-010 level  output  NUM_CH  debounced level per channel.
REQ-011 press  output  NUM_CH  one-clk pulse on accepted 0->1 change.
REQ-012 release  output  NUM_CH  one-clk pulse on accepted 1->0 change.
REQ-013 fire  output  NUM_CH  one-clk action pulse: on press and on each auto-repeat.

Function
REQ-014 raw_in SHALL pass through a 2-flop synchronizer per channel before any other use.
REQ-015 A shared divider SHALL count 0..SAMPLE_DIV-1 and wrap; tick is high for the one clk where the count equals SAMPLE_DIV-1 (every clk when SAMPLE_DIV=1).
REQ-016 On tick, per channel: if synced value equals level, stable counter clears; else it increments, and when it would reach STABLE_SAMPLES, level toggles and the counter clears.
REQ-017 Non-tick clocks SHALL leave debounce, state and repeat counters unchanged.
REQ-018 press/release/fire SHALL be registered and asserted exactly in the clk after the tick that causes them, for one clk only.
REQ-019 Per-channel FSM states: IDLE, HELD, REPEAT; reset state IDLE.
REQ-020 IDLE -> HELD on accepted rise: press=1, fire=1, repeat counter loaded with REPEAT_DELAY-1.
REQ-021 HELD: on tick with repeat_en=1, counter decrements; at 0, fire=1, counter loads REPEAT_RATE-1, -> REPEAT; with repeat_en=0 counter holds.
REQ-022 REPEAT: on tick with repeat_en=1, counter decrements; at 0, fire=1 and reload REPEAT_RATE-1; repeat_en=0 -> HELD with counter reloaded REPEAT_DELAY-1, no fire.
REQ-023 Any state -> IDLE on accepted fall: release=1, fire=0, counters cleared; fall takes priority over a simultaneous repeat expiry.
REQ-024 Channels SHALL be fully independent; simultaneous events on multiple channels all pulse in the same clk.
REQ-025 Raw glitches shorter than STABLE_SAMPLES consecutive ticks SHALL produce no output change.
REQ-026 Counter widths SHALL be ceil(log2(max value+1)), minimum 1 bit; no counter may wrap unintentionally.

Reset
REQ-027 While rst=1: synchronizers, divider, stable/repeat counters = 0, FSM = IDLE, level/press/release/fire = 0.
REQ-028 Reset mid-hold SHALL abort silently: no release pulse on reset or on deassertion; a still-pressed button after reset is re-accepted as a new press after STABLE_SAMPLES ticks.

Structure
REQ-029 Package input_pkg SHALL hold the FSM state enum (IDLE/HELD/REPEAT) and default parameter constants.
REQ-030 Per-channel logic SHALL be sub-module input_channel (synchronizer, debounce, FSM), instantiated NUM_CH times; divider stays in the top.

Verification (NUM_CH=2, SAMPLE_DIV=4, STABLE_SAMPLES=3, REPEAT_DELAY=5, REPEAT_RATE=2)
REQ-031 After reset, raw_in[0] held 1 -> level[0]=1 after 3 ticks; press[0], fire[0] one clk each, same clk; release[0]=0.
REQ-032 raw_in[0] 1 for 2 ticks then 0 -> level, press, fire stay 0 throughout.
REQ-033 Hold ch0 with repeat_en=1 for 12 ticks past press -> fire at press, +5 ticks, then every 2 ticks (+7, +9, +11).
REQ-034 Same with repeat_en=0 -> single fire at press only; release pulses 3 ticks after raw drop.
REQ-035 Both channels pressed same clk -> press=2'b11 in one clk; rst pulse mid-REPEAT -> all outputs 0, no release, re-press after 3 ticks.

Source files
------------

// File: rtl/input_pkg.sv
// input_pkg: shared FSM state type and default parameters for the input conditioner
package input_pkg;
  typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;
  localparam int DEF_NUM_CH = 5;
  localparam int DEF_SAMPLE_DIV = 11;
  localparam int DEF_STABLE_SAMPLES = 3;
  localparam int DEF_REPEAT_DELAY = 25;
  localparam int DEF_REPEAT_RATE = 6;
endpackage

// File: rtl/input_channel.sv
// input_channel: per-button synchronizer, tick-based debounce and press/auto-repeat FSM
module input_channel
  import input_pkg::*;
#(
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  input  logic repeat_en,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic fire
);
  localparam int SW = STABLE_SAMPLES > 1 ? $clog2(STABLE_SAMPLES) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) - 1;
  localparam int RW = RMAX > 0 ? $clog2(RMAX + 1) : 1;
  localparam logic [RW-1:0] LD_DELAY = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] LD_RATE = RW'(REPEAT_RATE - 1);
  logic [1:0] sync_q, sync_d;
  logic [SW-1:0] stb_q, stb_d;
  logic [RW-1:0] rep_q, rep_d;
  logic level_q, level_d, press_q, press_d, rel_q, rel_d, fire_q, fire_d;
  state_t state_q, state_d;
  always_comb begin
    sync_d = {sync_q[0], raw};
    stb_d = stb_q;
    level_d = level_q;
    state_d = state_q;
    rep_d = rep_q;
    press_d = 1'b0;
    rel_d = 1'b0;
    fire_d = 1'b0;
    if (tick) begin
      if (sync_q[1] == level_q) stb_d = '0;
      else if (32'(stb_q) + 32'd1 == 32'(STABLE_SAMPLES)) begin
        stb_d = '0;
        level_d = ~level_q;
      end else stb_d = stb_q + 1'b1;
      // an accepted fall wins over any repeat expiry on the same tick
      if (level_q && !level_d) begin
        state_d = IDLE;
        rep_d = '0;
        rel_d = 1'b1;
      end else if (!level_q && level_d) begin
        state_d = HELD;
        rep_d = LD_DELAY;
        press_d = 1'b1;
        fire_d = 1'b1;
      end else if (state_q == REPEAT && !repeat_en) begin
        state_d = HELD;
        rep_d = LD_DELAY;
      end else if (state_q != IDLE && repeat_en) begin
        if (rep_q == '0) begin
          fire_d = 1'b1;
          rep_d = LD_RATE;
          state_d = REPEAT;
        end else rep_d = rep_q - 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q <= '0;
      stb_q <= '0;
      rep_q <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q <= 1'b0;
      fire_q <= 1'b0;
      state_q <= IDLE;
    end else begin
      sync_q <= sync_d;
      stb_q <= stb_d;
      rep_q <= rep_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q <= rel_d;
      fire_q <= fire_d;
      state_q <= state_d;
    end
  assign level = level_q;
  assign press = press_q;
  assign release_pulse = rel_q;
  assign fire = fire_q;
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: shared sample-tick divider driving NUM_CH independent button channels
module input_conditioner
  import input_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE = DEF_REPEAT_RATE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] raw_in,
  input  logic [NUM_CH-1:0] repeat_en,
  output logic [NUM_CH-1:0] level,
  output logic [NUM_CH-1:0] press,
  output logic [NUM_CH-1:0] release_pulse,
  output logic [NUM_CH-1:0] fire
);
  localparam int DW = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;
  logic [DW-1:0] div_q, div_d;
  logic tick;
  always_comb begin
    tick = div_q == DW'(SAMPLE_DIV - 1);
    div_d = tick ? '0 : div_q + 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) div_q <= '0;
    else div_q <= div_d;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    input_channel #(
      .STABLE_SAMPLES(STABLE_SAMPLES),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE(REPEAT_RATE)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .tick(tick),
      .raw(raw_in[i]),
      .repeat_en(repeat_en[i]),
      .level(level[i]),
      .press(press[i]),
      .release_pulse(release_pulse[i]),
      .fire(fire[i])
    );
  end
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: scoreboard bench; expected pulse events are queued by tick index and checked by a monitor
module tb_input_conditioner;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] raw_in = '0, repeat_en = '0;
  logic [1:0] level, press, release_pulse, fire;
  int n_chk = 0, n_fail = 0;
  int div = 0, tick_n = 0;
  typedef struct {int tick; logic [1:0] p, r, f;} exp_t;
  exp_t q[$];

  input_conditioner #(
    .NUM_CH(2), .SAMPLE_DIV(4), .STABLE_SAMPLES(3), .REPEAT_DELAY(5), .REPEAT_RATE(2)
  ) dut (
    .clk(clk), .rst(rst), .raw_in(raw_in), .repeat_en(repeat_en),
    .level(level), .press(press), .release_pulse(release_pulse), .fire(fire)
  );

  always #5 clk = ~clk;

  // independent sample-tick model: tick_n counts ticks since reset release
  always @(posedge clk or posedge rst)
    if (rst) begin
      div <= 0;
      tick_n <= 0;
    end else if (div == 3) begin
      div <= 0;
      tick_n <= tick_n + 1;
    end else div <= div + 1;

  always @(negedge clk)
    if (!rst && (press | release_pulse | fire) != 2'b00) begin
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got tick=%0d p=%b r=%b f=%b, required none", tick_n, press, release_pulse, fire);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.tick != tick_n || e.p != press || e.r != release_pulse || e.f != fire) begin
          n_fail++;
          $display("FAIL event: got tick=%0d p=%b r=%b f=%b, required tick=%0d p=%b r=%b f=%b",
                   tick_n, press, release_pulse, fire, e.tick, e.p, e.r, e.f);
        end
      end
    end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (4 * n) @(negedge clk);
  endtask

  task automatic push(input int t, input logic [1:0] p, input logic [1:0] r, input logic [1:0] f);
    exp_t e;
    e.tick = t; e.p = p; e.r = r; e.f = f;
    q.push_back(e);
  endtask

  initial begin
    int k, p;
    repeat (3) @(negedge clk);
    check("reset_outputs", {24'd0, level, press, release_pulse, fire}, 32'd0);
    rst = 1'b0;
    // single press, no repeat, then release
    k = tick_n;
    raw_in = 2'b01;
    push(k + 3, 2'b01, 2'b00, 2'b01);
    wait_ticks(4);
    check("level_after_press", 32'(level), 32'd1);
    k = tick_n;
    raw_in = 2'b00;
    push(k + 3, 2'b00, 2'b01, 2'b00);
    wait_ticks(4);
    check("level_after_release", 32'(level), 32'd0);
    // glitch of two ticks must be filtered
    raw_in = 2'b01;
    wait_ticks(2);
    raw_in = 2'b00;
    wait_ticks(4);
    check("glitch_level", 32'(level), 32'd0);
    check("glitch_no_event", 32'(q.size()), 32'd0);
    // auto-repeat: fire at press, +5, +7, +9, +11
    k = tick_n;
    repeat_en = 2'b01;
    raw_in = 2'b01;
    p = k + 3;
    push(p, 2'b01, 2'b00, 2'b01);
    push(p + 5, 2'b00, 2'b00, 2'b01);
    push(p + 7, 2'b00, 2'b00, 2'b01);
    push(p + 9, 2'b00, 2'b00, 2'b01);
    push(p + 11, 2'b00, 2'b00, 2'b01);
    wait_ticks(15);
    check("repeat_level_held", 32'(level), 32'd1);
    repeat_en = 2'b00;
    raw_in = 2'b00;
    push(p + 15, 2'b00, 2'b01, 2'b00);
    wait_ticks(4);
    check("repeat_all_seen", 32'(q.size()), 32'd0);
    // held without repeat: single fire, release 3 ticks after drop
    k = tick_n;
    raw_in = 2'b01;
    push(k + 3, 2'b01, 2'b00, 2'b01);
    wait_ticks(15);
    k = tick_n;
    raw_in = 2'b00;
    push(k + 3, 2'b00, 2'b01, 2'b00);
    wait_ticks(4);
    check("norepeat_all_seen", 32'(q.size()), 32'd0);
    // both channels together, then reset in the middle of REPEAT
    k = tick_n;
    repeat_en = 2'b11;
    raw_in = 2'b11;
    p = k + 3;
    push(p, 2'b11, 2'b00, 2'b11);
    push(p + 5, 2'b00, 2'b00, 2'b11);
    push(p + 7, 2'b00, 2'b00, 2'b11);
    wait_ticks(11);
    check("dual_level", 32'(level), 32'd3);
    check("dual_all_seen", 32'(q.size()), 32'd0);
    rst = 1'b1;
    repeat_en = 2'b00;
    repeat (3) @(negedge clk);
    check("midhold_reset_outputs", {24'd0, level, press, release_pulse, fire}, 32'd0);
    rst = 1'b0;
    push(3, 2'b11, 2'b00, 2'b11);
    wait_ticks(4);
    check("repress_level", 32'(level), 32'd3);
    raw_in = 2'b00;
    push(7, 2'b00, 2'b11, 2'b00);
    wait_ticks(4);
    check("final_level", 32'(level), 32'd0);
    check("final_queue_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
